// File: rtl/pong_pkg.sv
// Shared types, default screen geometry and the paddle/ball overlap test
// for the Pong game core.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int H_RES_DEF     = 640;
    localparam int V_RES_DEF     = 480;
    localparam int PADDLE_W_DEF  = 10;
    localparam int PADDLE_H_DEF  = 50;
    localparam int BALL_SIZE_DEF = 7;

    // True when the ball's vertical span intersects the paddle's vertical span.
    function automatic logic overlap(input logic [9:0] ball_y,
                                     input logic [9:0] pad_y,
                                     input int         ball_size = BALL_SIZE_DEF,
                                     input int         paddle_h  = PADDLE_H_DEF);
        logic [10:0] ball_bot;
        logic [10:0] pad_bot;
        ball_bot = {1'b0, ball_y} + 11'(ball_size);
        pad_bot  = {1'b0, pad_y} + 11'(paddle_h);
        return (ball_bot > {1'b0, pad_y}) && ({1'b0, ball_y} < pad_bot);
    endfunction

endpackage

// File: rtl/pong_game_engine_paddle_ctrl.sv
// Saturating paddle position register: moves PADDLE_STEP pixels per frame
// tick while exactly one button is held, clamped to the visible area.
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int V_RES       = V_RES_DEF,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int PADDLE_STEP = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       freeze,
    input  logic       recenter,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y
);

    localparam logic [9:0] Y_MAX  = 10'(V_RES - PADDLE_H);
    localparam logic [9:0] Y_INIT = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] STEP   = 10'(PADDLE_STEP);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            y <= Y_INIT;
        end else if (recenter) begin
            y <= Y_INIT;
        end else if (tick && !freeze) begin
            // Compare before subtracting/adding so the register never wraps.
            if (up && !down) begin
                y <= (y < STEP) ? 10'd0 : y - STEP;
            end else if (down && !up) begin
                y <= (({1'b0, y} + {1'b0, STEP}) > {1'b0, Y_MAX}) ? Y_MAX : y + STEP;
            end
        end
    end

endmodule

// File: rtl/pong_game_engine.sv
// Frame-rate Pong core: paddles, ball motion, bounces, scoring and the
// IDLE/SERVE/PLAY/GAME_OVER flow, advancing once per frame_tick.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    input  logic               start,
    output logic [9:0]         p1_y,
    output logic [9:0]         p2_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         game_state,
    output logic               point_p1,
    output logic               point_p2,
    output logic               game_over
);

    localparam int               CNT_W       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0]       BALL_X0     = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL_Y0     = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]       Y_BOT       = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0]       STEP_B      = 10'(BALL_STEP);
    localparam logic [9:0]       X_LEFT      = 10'(PADDLE_W);
    localparam logic [9:0]       X_RIGHT     = 10'(H_RES - PADDLE_W - BALL_SIZE);
    localparam logic [9:0]       X_LEFT_EDGE = 10'(PADDLE_W + BALL_STEP);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    game_state_t        state, state_n;
    logic [9:0]         bx_n, by_n, vy;
    logic               dx, dy, dx_n, dy_n, vdy;
    logic [CNT_W-1:0]   serve_cnt, cnt_n;
    logic [SCORE_W-1:0] s1_n, s2_n;
    logic               pt1_n, pt2_n;
    logic               recenter, frozen;

    assign frozen     = (state == GAME_OVER);
    assign game_state = state;

    pong_paddle_ctrl #(
        .V_RES      (V_RES),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_STEP(PADDLE_STEP)
    ) u_paddle_p1 (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .tick    (frame_tick),
        .freeze  (frozen),
        .recenter(recenter),
        .up      (p1_up),
        .down    (p1_down),
        .y       (p1_y)
    );

    pong_paddle_ctrl #(
        .V_RES      (V_RES),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_STEP(PADDLE_STEP)
    ) u_paddle_p2 (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .tick    (frame_tick),
        .freeze  (frozen),
        .recenter(recenter),
        .up      (p2_up),
        .down    (p2_down),
        .y       (p2_y)
    );

    always_comb begin
        state_n  = state;
        bx_n     = ball_x;
        by_n     = ball_y;
        dx_n     = dx;
        dy_n     = dy;
        cnt_n    = serve_cnt;
        s1_n     = p1_score;
        s2_n     = p2_score;
        pt1_n    = 1'b0;
        pt2_n    = 1'b0;
        recenter = 1'b0;

        // Vertical candidate, applied only if no point is scored this tick.
        vy  = dy ? ball_y + STEP_B : ball_y - STEP_B;
        vdy = dy;
        if (!dy && ball_y < STEP_B) begin
            vy  = 10'd0;
            vdy = 1'b1;
        end else if (dy && ({1'b0, ball_y} + {1'b0, STEP_B}) > {1'b0, Y_BOT}) begin
            vy  = Y_BOT;
            vdy = 1'b0;
        end

        case (state)
            IDLE: begin
                bx_n = BALL_X0;
                by_n = BALL_Y0;
                if (start) begin
                    state_n = SERVE;
                    cnt_n   = '0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt == CNT_LAST) state_n = PLAY;
                    else                       cnt_n   = serve_cnt + CNT_W'(1);
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    by_n = vy;
                    dy_n = vdy;
                    if (!dx && ball_x < X_LEFT_EDGE) begin
                        if (overlap(ball_y, p1_y, BALL_SIZE, PADDLE_H)) begin
                            bx_n = X_LEFT;
                            dx_n = 1'b1;
                        end else begin
                            s2_n    = p2_score + SCORE_W'(1);
                            pt2_n   = 1'b1;
                            bx_n    = BALL_X0;
                            by_n    = BALL_Y0;
                            dx_n    = 1'b0;
                            dy_n    = dy;
                            cnt_n   = '0;
                            state_n = (s2_n == WIN) ? GAME_OVER : SERVE;
                        end
                    end else if (dx && ({1'b0, ball_x} + {1'b0, STEP_B}) > {1'b0, X_RIGHT}) begin
                        if (overlap(ball_y, p2_y, BALL_SIZE, PADDLE_H)) begin
                            bx_n = X_RIGHT;
                            dx_n = 1'b0;
                        end else begin
                            s1_n    = p1_score + SCORE_W'(1);
                            pt1_n   = 1'b1;
                            bx_n    = BALL_X0;
                            by_n    = BALL_Y0;
                            dx_n    = 1'b1;
                            dy_n    = dy;
                            cnt_n   = '0;
                            state_n = (s1_n == WIN) ? GAME_OVER : SERVE;
                        end
                    end else begin
                        bx_n = dx ? ball_x + STEP_B : ball_x - STEP_B;
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    s1_n     = '0;
                    s2_n     = '0;
                    bx_n     = BALL_X0;
                    by_n     = BALL_Y0;
                    recenter = 1'b1;
                    cnt_n    = '0;
                    state_n  = SERVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            serve_cnt <= '0;
            p1_score  <= '0;
            p2_score  <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            ball_x    <= bx_n;
            ball_y    <= by_n;
            dx        <= dx_n;
            dy        <= dy_n;
            serve_cnt <= cnt_n;
            p1_score  <= s1_n;
            p2_score  <= s2_n;
            point_p1  <= pt1_n;
            point_p2  <= pt2_n;
            game_over <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_pong_game_engine.sv
// Randomised bench for pong_game_engine against an integer game model.
module tb_pong_game_engine;

    localparam int H = 640, V = 480, PW = 10, PH = 50, BS = 7;
    localparam int PS = 4, BST = 2, SF = 60, WS = 2, SW = 4;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_tick = 1'b0, start = 1'b0;
    logic          p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic [9:0]    p1_y, p2_y, ball_x, ball_y;
    logic [SW-1:0] p1_score, p2_score;
    logic [1:0]    game_state;
    logic          point_p1, point_p2, game_over;

    pong_game_engine #(
        .H_RES(H), .V_RES(V), .PADDLE_W(PW), .PADDLE_H(PH), .BALL_SIZE(BS),
        .PADDLE_STEP(PS), .BALL_STEP(BST), .SERVE_FRAMES(SF),
        .WIN_SCORE(WS), .SCORE_W(SW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .start(start), .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
        .p1_score(p1_score), .p2_score(p2_score), .game_state(game_state),
        .point_p1(point_p1), .point_p2(point_p2), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;

    // Model state: game_state uses the output numbering 0..3, directions are +1/-1.
    int m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_cnt, m_pt1, m_pt2;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p1y = (V - PH) / 2;  m_p2y = (V - PH) / 2;
        m_bx  = (H - BS) / 2;  m_by  = (V - BS) / 2;
        m_dx  = 1;  m_dy = 1;  m_s1 = 0;  m_s2 = 0;
        m_st  = 0;  m_cnt = 0; m_pt1 = 0; m_pt2 = 0;
    endtask

    function automatic int pmove(input int y, input bit u, input bit d);
        if (u && !d) return (y - PS < 0) ? 0 : y - PS;
        if (d && !u) return (y + PS > V - PH) ? V - PH : y + PS;
        return y;
    endfunction

    function automatic bit hits(input int by, input int py);
        return (by + BS > py) && (by < py + PH);
    endfunction

    task automatic model_step(input bit tk, input bit st, input bit u1, input bit d1,
                              input bit u2, input bit d2);
        int op1, op2, ny, ndy, scorer;
        op1 = m_p1y;  op2 = m_p2y;
        m_pt1 = 0;    m_pt2 = 0;
        if (tk && m_st != 3) begin
            m_p1y = pmove(op1, u1, d1);
            m_p2y = pmove(op2, u2, d2);
        end
        case (m_st)
            0: if (st) begin m_st = 1; m_cnt = 0; end
            1: if (tk) begin
                   if (m_cnt == SF - 1) m_st = 2;
                   else m_cnt++;
               end
            2: if (tk) begin
                   ny = m_by + m_dy * BST;  ndy = m_dy;
                   if (m_dy < 0 && m_by < BST) begin ny = 0; ndy = 1; end
                   else if (m_dy > 0 && m_by + BST > V - BS) begin ny = V - BS; ndy = -1; end
                   scorer = 0;
                   if (m_dx < 0 && m_bx < PW + BST) begin
                       if (hits(m_by, op1)) begin m_bx = PW; m_dx = 1; end
                       else scorer = 2;
                   end else if (m_dx > 0 && m_bx + BST > H - PW - BS) begin
                       if (hits(m_by, op2)) begin m_bx = H - PW - BS; m_dx = -1; end
                       else scorer = 1;
                   end else begin
                       m_bx += m_dx * BST;
                   end
                   if (scorer == 0) begin
                       m_by = ny;  m_dy = ndy;
                   end else begin
                       m_bx = (H - BS) / 2;  m_by = (V - BS) / 2;  m_cnt = 0;
                       if (scorer == 1) begin
                           m_s1++;  m_pt1 = 1;  m_dx = 1;
                           m_st = (m_s1 == WS) ? 3 : 1;
                       end else begin
                           m_s2++;  m_pt2 = 1;  m_dx = -1;
                           m_st = (m_s2 == WS) ? 3 : 1;
                       end
                   end
               end
            default: if (st) begin
                   m_s1 = 0;  m_s2 = 0;
                   m_bx = (H - BS) / 2;  m_by = (V - BS) / 2;
                   m_p1y = (V - PH) / 2; m_p2y = (V - PH) / 2;
                   m_st = 1;  m_cnt = 0;
               end
        endcase
    endtask

    task automatic check_all();
        chk("p1_y", int'(p1_y), m_p1y);
        chk("p2_y", int'(p2_y), m_p2y);
        chk("ball_x", int'(ball_x), m_bx);
        chk("ball_y", int'(ball_y), m_by);
        chk("p1_score", int'(p1_score), m_s1);
        chk("p2_score", int'(p2_score), m_s2);
        chk("game_state", int'(game_state), m_st);
        chk("point_p1", int'(point_p1), m_pt1);
        chk("point_p2", int'(point_p2), m_pt2);
        chk("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
    endtask

    task automatic step(input bit tk, input bit st, input bit u1, input bit d1,
                        input bit u2, input bit d2);
        @(negedge CLOCK_50);
        frame_tick = tk;  start = st;
        p1_up = u1;  p1_down = d1;  p2_up = u2;  p2_down = d2;
        @(posedge CLOCK_50);
        #1;
        model_step(tk, st, u1, d1, u2, d2);
        check_all();
    endtask

    // A frame tick followed by a quiet cycle, so non-tick cycles are exercised too.
    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
        step(1'b1, 1'b0, u1, d1, u2, d2);
        step(1'b0, 1'b0, u1, d1, u2, d2);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_p1_y"}, int'(p1_y), 215);
        chk({tag, "_p2_y"}, int'(p2_y), 215);
        chk({tag, "_ball_x"}, int'(ball_x), 316);
        chk({tag, "_ball_y"}, int'(ball_y), 236);
        chk({tag, "_scores"}, int'(p1_score) + int'(p2_score), 0);
        chk({tag, "_state"}, int'(game_state), 0);
        chk({tag, "_pulses"}, int'(point_p1) + int'(point_p2) + int'(game_over), 0);
    endtask

    task automatic hard_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;  frame_tick = 1'b0;  start = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        model_reset();
        check_reset_values("rst");
        @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    initial begin
        bit u1, d1, u2, d2, tk, st;
        int ticks;

        // Serve timing, first move, bottom bounce and a right-paddle hit.
        hard_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_to_serve", int'(game_state), 1);
        for (int i = 0; i < SF; i++) frame(rb(), rb(), 1'b0, 1'b0);
        chk("serve_done_state", int'(game_state), 2);
        chk("serve_held_x", int'(ball_x), 316);
        chk("serve_held_y", int'(ball_y), 236);
        for (int t = 1; t <= 154; t++) begin
            frame(rb(), rb(), 1'b0, t <= 46);
            if (t == 1)   begin chk("first_x", int'(ball_x), 318); chk("first_y", int'(ball_y), 238); end
            if (t == 46)  chk("p2_down_46", int'(p2_y), 399);
            if (t == 119) chk("bottom_clamp", int'(ball_y), 473);
            if (t == 120) begin chk("bounce_y", int'(ball_y), 471); chk("bounce_x", int'(ball_x), 556); end
            if (t == 154) begin chk("hit_x", int'(ball_x), 623); chk("hit_no_point", int'(point_p1), 0); end
        end

        // p2 saturates at the top and misses: point to p1.
        hard_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SF; i++) frame(rb(), rb(), 1'b1, 1'b0);
        chk("p2_top_sat", int'(p2_y), 0);
        for (int t = 1; t <= 154; t++) begin
            step(1'b1, 1'b0, rb(), rb(), 1'b1, 1'b0);
            if (t == 154) begin
                chk("miss_point_p1", int'(point_p1), 1);
                chk("miss_score", int'(p1_score), 1);
                chk("miss_recentre_x", int'(ball_x), 316);
                chk("miss_recentre_y", int'(ball_y), 236);
                chk("miss_to_serve", int'(game_state), 1);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("point_pulse_ends", int'(point_p1), 0);

        // p1 dodges, p2 tracks the ball, until the game ends.
        ticks = 0;
        while (m_st != 3 && ticks < 6000) begin
            u1 = (m_by > 240);  d1 = !u1;
            u2 = (m_p2y + 25 > m_by + 5);
            d2 = (m_p2y + 25 < m_by + 1);
            step(1'b1, 1'b0, u1, d1, u2, d2);
            ticks++;
        end
        chk("reach_game_over", int'(game_over), 1);
        chk("game_over_state", int'(game_state), 3);
        for (int i = 0; i < 20; i++) frame(rb(), rb(), rb(), rb());
        step(1'b1, 1'b1, rb(), rb(), rb(), rb());
        chk("restart_scores", int'(p1_score) + int'(p2_score), 0);
        chk("restart_state", int'(game_state), 1);
        chk("restart_p1_y", int'(p1_y), 215);

        // Asynchronous reset between edges in PLAY, then both p1 buttons held.
        for (int i = 0; i < SF + 10; i++) frame(rb(), rb(), rb(), rb());
        @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) frame(1'b1, 1'b1, rb(), rb());
        chk("both_held_p1_y", int'(p1_y), 215);

        // Free-running random stimulus.
        for (int i = 0; i < 3000; i++) begin
            tk = rb();
            st = ($urandom_range(0, 15) == 0);
            step(tk, st, rb(), rb(), rb(), rb());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
